// File: rtl/wb_dest_pipe.sv
// ---------------------------------------------------------------------------
// wb_dest_pipe
//   Write-back destination unit for the multicycle MIPS datapath. It selects
//   the destination register (rd, rt, $ra or $sp), then carries it through a
//   DEPTH-stage delay line so that it reaches the register-file write port in
//   step with write-back. Every stage that holds a valid entry also serves as
//   a scoreboard slot for read-after-write hazard detection on two source
//   indices.
//
// Ports
//   clk        system clock (rising edge)
//   reset      asynchronous, active-low reset
//   issue      capture a destination this cycle
//   wr_sel     00 rd / 01 rt / 10 RA_REG / 11 SP_REG
//   rd, rt     decoded instruction register fields
//   stall      freeze the delay line, suppress write-back
//   flush      kill all in-flight entries (a concurrent issue still enters)
//   src_a/b    hazard query indices
//   hazard_a/b combinational: a valid in-flight entry matches src_a/src_b
//   wb_valid   register-file write enable
//   wb_reg     register-file write index (don't-care while wb_valid=0)
//   in_flight  registered count of valid entries in the delay line
// ---------------------------------------------------------------------------

// One delay-line stage: a {valid, reg} pair with load and kill controls.
// kill has priority and only clears the valid bit; the stale index is left
// in place because nothing looks at it while valid is low.
module wb_dest_stage #(
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             kill,
    input  logic             d_vld,
    input  logic [REG_W-1:0] d_reg,
    output logic             q_vld,
    output logic [REG_W-1:0] q_reg
);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_vld <= 1'b0;
            q_reg <= '0;
        end else if (kill) begin
            q_vld <= 1'b0;
        end else if (load) begin
            q_vld <= d_vld;
            q_reg <= d_reg;
        end
    end
endmodule

module wb_dest_pipe #(
    parameter int REG_W  = 5,
    parameter int DEPTH  = 3,
    parameter int RA_REG = 31,
    parameter int SP_REG = 29,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [1:0]       wr_sel,
    input  logic [REG_W-1:0] rd,
    input  logic [REG_W-1:0] rt,
    input  logic             stall,
    input  logic             flush,
    input  logic [REG_W-1:0] src_a,
    input  logic [REG_W-1:0] src_b,
    output logic             hazard_a,
    output logic             hazard_b,
    output logic             wb_valid,
    output logic [REG_W-1:0] wb_reg,
    output logic [CNT_W-1:0] in_flight
);
    logic [REG_W-1:0] dest;
    logic             vin;
    logic             adv;

    // Stage state and per-stage next-value controls.
    logic [DEPTH-1:0]            vld_pipe;
    logic [DEPTH-1:0][REG_W-1:0] reg_pipe;
    logic [DEPTH-1:0]            stg_load;
    logic [DEPTH-1:0]            stg_kill;
    logic [DEPTH-1:0]            stg_d_vld;
    logic [DEPTH-1:0][REG_W-1:0] stg_d_reg;
    logic [DEPTH-1:0]            vld_nxt;
    logic [CNT_W-1:0]            pop_nxt;

    always_comb begin
        case (wr_sel)
            2'b00:   dest = rd;
            2'b01:   dest = rt;
            2'b10:   dest = REG_W'(RA_REG);
            default: dest = REG_W'(SP_REG);
        endcase
    end

    // Writes to $zero are architecturally discarded, so they never occupy a
    // scoreboard slot and never raise a write enable.
    assign vin = issue & (dest != '0);
    assign adv = ~stall & ~flush;

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_stg
            if (i == 0) begin : g_head
                // Flush overrides stall here: the redirect target is captured
                // even when the line is otherwise frozen.
                assign stg_load[i]  = flush | ~stall;
                assign stg_kill[i]  = 1'b0;
                assign stg_d_vld[i] = vin;
                assign stg_d_reg[i] = dest;
            end else begin : g_body
                assign stg_load[i]  = adv;
                assign stg_kill[i]  = flush;
                assign stg_d_vld[i] = vld_pipe[i-1];
                assign stg_d_reg[i] = reg_pipe[i-1];
            end

            wb_dest_stage #(.REG_W(REG_W)) u_stg (
                .clk   (clk),
                .reset (reset),
                .load  (stg_load[i]),
                .kill  (stg_kill[i]),
                .d_vld (stg_d_vld[i]),
                .d_reg (stg_d_reg[i]),
                .q_vld (vld_pipe[i]),
                .q_reg (reg_pipe[i])
            );

            // Mirror of the stage's valid update, used to register the
            // occupancy count on the same edge as the stages themselves.
            assign vld_nxt[i] = stg_kill[i] ? 1'b0 :
                                stg_load[i] ? stg_d_vld[i] : vld_pipe[i];
        end
    endgenerate

    always_comb begin
        pop_nxt = '0;
        for (int i = 0; i < DEPTH; i++)
            pop_nxt = pop_nxt + CNT_W'(vld_nxt[i]);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) in_flight <= '0;
        else        in_flight <= pop_nxt;
    end

    // The tail is part of the hazard window: the register file has no
    // write-to-read bypass, so the value is not readable until the cycle
    // after write-back.
    logic hit_a, hit_b;
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld_pipe[i] && (reg_pipe[i] == src_a)) hit_a = 1'b1;
            if (vld_pipe[i] && (reg_pipe[i] == src_b)) hit_b = 1'b1;
        end
    end

    assign hazard_a = hit_a & (src_a != '0);
    assign hazard_b = hit_b & (src_b != '0);

    // A stalled tail is held for another cycle, so its write is suppressed
    // now and happens once when the line moves again.
    assign wb_valid = vld_pipe[DEPTH-1] & adv;
    assign wb_reg   = reg_pipe[DEPTH-1];

endmodule

// File: tb/tb_wb_dest_pipe.sv
module tb_wb_dest_pipe;
    localparam int REG_W = 5;
    localparam int DEPTH = 3;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             issue = 1'b0;
    logic [1:0]       wr_sel = 2'b00;
    logic [REG_W-1:0] rd = '0, rt = '0;
    logic             stall = 1'b0, flush = 1'b0;
    logic [REG_W-1:0] src_a = '0, src_b = '0;
    logic             hazard_a, hazard_b, wb_valid;
    logic [REG_W-1:0] wb_reg;
    logic [CNT_W-1:0] in_flight;

    wb_dest_pipe #(.REG_W(REG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset_n), .issue(issue), .wr_sel(wr_sel),
        .rd(rd), .rt(rt), .stall(stall), .flush(flush),
        .src_a(src_a), .src_b(src_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
        .wb_valid(wb_valid), .wb_reg(wb_reg), .in_flight(in_flight)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: list of in-flight destinations, each tagged with how
    // many advancing edges it has seen since capture. An entry is at the
    // write-back point once it has advanced DEPTH-1 times.
    int mq_reg[$];
    int mq_pos[$];

    // Per-segment history of observed outputs (sampled mid-cycle).
    int seg_cyc;
    logic wbv_h[64];
    int   wbr_h[64];
    logic ha_h[64];
    logic hb_h[64];
    int   inf_h[64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int sel_dest();
        case (wr_sel)
            2'b00:   return int'(rd);
            2'b01:   return int'(rt);
            2'b10:   return 31;
            default: return 29;
        endcase
    endfunction

    function automatic int tail_reg();
        for (int k = 0; k < mq_pos.size(); k++)
            if (mq_pos[k] == DEPTH - 1) return mq_reg[k];
        return -1;
    endfunction

    function automatic logic model_hit(input int s);
        if (s == 0) return 1'b0;
        foreach (mq_reg[k]) if (mq_reg[k] == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        mq_reg.delete();
        mq_pos.delete();
    endtask

    task automatic model_update();
        int d;
        logic v;
        d = sel_dest();
        v = issue && (d != 0);
        if (!reset_n) begin
            model_clear();
        end else if (flush) begin
            model_clear();
            if (v) begin mq_reg.push_back(d); mq_pos.push_back(0); end
        end else if (!stall) begin
            for (int k = mq_pos.size() - 1; k >= 0; k--) begin
                mq_pos[k] = mq_pos[k] + 1;
                if (mq_pos[k] >= DEPTH) begin
                    mq_pos.delete(k);
                    mq_reg.delete(k);
                end
            end
            if (v) begin mq_reg.push_back(d); mq_pos.push_back(0); end
        end
    endtask

    // One clock cycle: compare against the model mid-cycle, log the observed
    // outputs, then advance the model on the rising edge.
    task automatic tick();
        int  t;
        logic ev;
        @(negedge clk);
        t  = tail_reg();
        ev = (t >= 0) && !stall && !flush && reset_n;
        chk("wb_valid", 32'(wb_valid), 32'(ev));
        if (ev) chk("wb_reg", 32'(wb_reg), 32'(t));
        chk("hazard_a", 32'(hazard_a), 32'(model_hit(int'(src_a))));
        chk("hazard_b", 32'(hazard_b), 32'(model_hit(int'(src_b))));
        chk("in_flight", 32'(in_flight), 32'(mq_reg.size()));
        if (seg_cyc < 64) begin
            wbv_h[seg_cyc] = wb_valid;
            wbr_h[seg_cyc] = int'(wb_reg);
            ha_h[seg_cyc]  = hazard_a;
            hb_h[seg_cyc]  = hazard_b;
            inf_h[seg_cyc] = int'(in_flight);
        end
        @(posedge clk);
        model_update();
        #1;
        seg_cyc++;
    endtask

    task automatic idle();
        issue = 1'b0; stall = 1'b0; flush = 1'b0;
    endtask

    task automatic put(input logic [1:0] s, input int r_d, input int r_t);
        issue = 1'b1; wr_sel = s; rd = REG_W'(r_d); rt = REG_W'(r_t);
    endtask

    task automatic drain();
        idle();
        for (int k = 0; k < DEPTH + 1; k++) tick();
        seg_cyc = 0;
    endtask

    initial begin
        int cnt, last;
        int exp_sel[4];
        exp_sel = '{8, 9, 31, 29};

        // Reset state
        #3;
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_in_flight", 32'(in_flight), 32'd0);
        chk("rst_hazard_a", 32'(hazard_a), 32'd0);
        seg_cyc = 0;
        tick();
        reset_n = 1'b1;
        drain();

        // Select modes
        put(2'b00, 8, 1);  tick();
        put(2'b01, 2, 9);  tick();
        put(2'b10, 3, 4);  tick();
        put(2'b11, 5, 6);  tick();
        idle();
        for (int k = 0; k < 4; k++) tick();
        chk("sel_early", 32'(wbv_h[2]), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("sel_wbv", 32'(wbv_h[k+3]), 32'd1);
            chk("sel_wbr", 32'(wbr_h[k+3]), 32'(exp_sel[k]));
        end
        drain();

        // $zero filter
        src_a = '0;
        put(2'b00, 0, 7); tick();
        idle();
        for (int k = 0; k < 4; k++) tick();
        for (int k = 0; k < 5; k++) begin
            chk("zero_inf", 32'(inf_h[k]), 32'd0);
            chk("zero_wbv", 32'(wbv_h[k]), 32'd0);
            chk("zero_ha", 32'(ha_h[k]), 32'd0);
        end
        drain();

        // Hazard window
        src_a = 5; src_b = 6;
        put(2'b01, 1, 5); tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        cnt = 0; last = -1;
        for (int k = 0; k < 6; k++) begin
            if (ha_h[k]) begin cnt++; last = k; end
            chk("haz_b_quiet", 32'(hb_h[k]), 32'd0);
        end
        chk("haz_a_cycles", 32'(cnt), 32'd3);
        chk("haz_last_wb", 32'((last >= 0) ? wbv_h[last] : 1'b0), 32'd1);
        src_a = '0; src_b = '0;
        drain();

        // Stall
        put(2'b00, 12, 0); tick();
        idle(); stall = 1'b1; tick(); tick();
        stall = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        cnt = 0;
        for (int k = 0; k < 8; k++) if (wbv_h[k]) cnt++;
        chk("stall_once", 32'(cnt), 32'd1);
        chk("stall_wbv5", 32'(wbv_h[5]), 32'd1);
        chk("stall_wbr5", 32'(wbr_h[5]), 32'd12);
        for (int k = 1; k <= 3; k++) chk("stall_inf", 32'(inf_h[k]), 32'd1);
        drain();

        // Flush plus issue
        put(2'b00, 3, 0); tick();
        put(2'b00, 4, 0); tick();
        put(2'b00, 5, 0); tick();
        put(2'b00, 7, 0); flush = 1'b1; tick();
        idle();
        for (int k = 0; k < 5; k++) tick();
        chk("flush_inf", 32'(inf_h[4]), 32'd1);
        cnt = 0;
        for (int k = 0; k < 9; k++)
            if (wbv_h[k] && (wbr_h[k] >= 3) && (wbr_h[k] <= 5)) cnt++;
        chk("flush_killed", 32'(cnt), 32'd0);
        chk("flush_wbv6", 32'(wbv_h[6]), 32'd1);
        chk("flush_wbr6", 32'(wbr_h[6]), 32'd7);
        drain();

        // Asynchronous reset mid-stream
        src_a = 10; src_b = 11;
        put(2'b00, 10, 0); tick();
        put(2'b00, 11, 0); tick();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_wbv", 32'(wb_valid), 32'd0);
        chk("arst_ha", 32'(hazard_a), 32'd0);
        chk("arst_hb", 32'(hazard_b), 32'd0);
        chk("arst_inf", 32'(in_flight), 32'd0);
        model_clear();
        tick();
        reset_n = 1'b1;
        seg_cyc = 0;
        for (int k = 0; k < 5; k++) tick();
        cnt = 0;
        for (int k = 0; k < 5; k++) if (wbv_h[k]) cnt++;
        chk("arst_no_stale", 32'(cnt), 32'd0);
        src_a = '0; src_b = '0;
        drain();

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            issue  = ($urandom_range(0, 3) != 0);
            wr_sel = 2'($urandom_range(0, 3));
            rd     = REG_W'($urandom_range(0, 7));
            rt     = REG_W'($urandom_range(0, 7));
            stall  = ($urandom_range(0, 7) == 0);
            flush  = ($urandom_range(0, 15) == 0);
            src_a  = REG_W'($urandom_range(0, 7));
            src_b  = ($urandom_range(0, 3) == 0) ? REG_W'(29 + 2 * $urandom_range(0, 1))
                                                 : REG_W'($urandom_range(0, 7));
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
